// File: rtl/cpu_bus_arbiter.sv
// CPU/DMA bus arbiter for the 8501: drives rdy/aec so the CPU is halted
// before the bus is handed over and owns the bus again before it resumes.
//
// Ports:
//   clk, reset   system clock, synchronous active-high reset
//   cyc_en       one-clk strobe per CPU cycle; all state advances on it
//   dma_req      level request from the DMA master
//   cpu_rw       CPU rw this cycle (1 = read), used only with fast grant
//   cpu_rdy      to CPU rdy (low = halt on next read)
//   cpu_aec      to CPU aec (low = CPU off the bus)
//   dma_grant    DMA master owns the bus this CPU cycle
//   busy         arbiter is not idle
//   dma_cycles   granted cycles in current/last burst, saturating
//
// Build option: define CPU_BUS_ARB_FAST_GRANT_EN to grant as soon as the
// CPU is seen halted on a read, instead of always waiting STALL_CYCLES.

module cpu_bus_arbiter #(
  parameter int unsigned STALL_CYCLES = 3,
  parameter int unsigned CNT_W        = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cyc_en,
  input  logic             dma_req,
  input  logic             cpu_rw,
  output logic             cpu_rdy,
  output logic             cpu_aec,
  output logic             dma_grant,
  output logic             busy,
  output logic [CNT_W-1:0] dma_cycles
);

  typedef enum logic [1:0] {
    IDLE,
    STALL,
    DMA,
    RELEASE
  } state_t;

  localparam logic [2:0] CNT_INIT = 3'(STALL_CYCLES - 1);

  state_t           state;
  state_t           state_nx;
  logic [2:0]       cnt;
  logic [2:0]       cnt_nx;
  logic [CNT_W-1:0] cyc_nx;
  logic             fast;

`ifdef CPU_BUS_ARB_FAST_GRANT_EN
  // A read cycle seen while rdy is low means the CPU is already halted.
  assign fast = cpu_rw;
`else
  // cpu_rw has no effect in this build.
  assign fast = 1'b0 & cpu_rw;
`endif

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cyc_nx   = dma_cycles;
    unique case (state)
      IDLE: begin
        if (dma_req) begin
          state_nx = STALL;
          cnt_nx   = CNT_INIT;
          cyc_nx   = '0;
        end
      end
      STALL: begin
        // Abort outranks both the count expiring and a fast grant.
        if (!dma_req) begin
          state_nx = IDLE;
        end else if (cnt == 3'd0 || fast) begin
          state_nx = DMA;
        end else begin
          cnt_nx = cnt - 3'd1;
        end
      end
      DMA: begin
        if (!(&dma_cycles)) begin
          cyc_nx = dma_cycles + 1'b1;
        end
        if (!dma_req) begin
          state_nx = RELEASE;
        end
      end
      RELEASE: begin
        // CPU is still halted here, so a new request skips the stall.
        if (dma_req) begin
          state_nx = DMA;
        end else begin
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Pin outputs are registered copies decoded from the next state, so
  // aec can only fall once rdy is already low and rises before rdy does.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= 3'd0;
      dma_cycles <= '0;
      cpu_rdy    <= 1'b1;
      cpu_aec    <= 1'b1;
      dma_grant  <= 1'b0;
      busy       <= 1'b0;
    end else if (cyc_en) begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      dma_cycles <= cyc_nx;
      cpu_rdy    <= (state_nx == IDLE);
      cpu_aec    <= (state_nx != DMA);
      dma_grant  <= (state_nx == DMA);
      busy       <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_cpu_bus_arbiter.sv
// Scoreboard bench for cpu_bus_arbiter: directed strobes push expected
// outputs, a negedge monitor pops and compares them.

module tb_cpu_bus_arbiter;

  logic       clk = 1'b0;
  logic       reset;
  logic       cyc_en;
  logic       dma_req;
  logic       cpu_rw;
  logic       cpu_rdy;
  logic       cpu_aec;
  logic       dma_grant;
  logic       busy;
  logic [7:0] dma_cycles;
  logic       s_rdy;
  logic       s_aec;
  logic       s_grant;
  logic       s_busy;
  logic [3:0] s_cycles;

  typedef struct {
    logic [3:0] ragb;
    logic [7:0] cyc;
    logic [3:0] cyc4;
    string      name;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  cpu_bus_arbiter u_dut (
    .clk        (clk),
    .reset      (reset),
    .cyc_en     (cyc_en),
    .dma_req    (dma_req),
    .cpu_rw     (cpu_rw),
    .cpu_rdy    (cpu_rdy),
    .cpu_aec    (cpu_aec),
    .dma_grant  (dma_grant),
    .busy       (busy),
    .dma_cycles (dma_cycles)
  );

  cpu_bus_arbiter #(.CNT_W(4)) u_sat (
    .clk        (clk),
    .reset      (reset),
    .cyc_en     (cyc_en),
    .dma_req    (dma_req),
    .cpu_rw     (cpu_rw),
    .cpu_rdy    (s_rdy),
    .cpu_aec    (s_aec),
    .dma_grant  (s_grant),
    .busy       (s_busy),
    .dma_cycles (s_cycles)
  );

  always @(negedge clk) begin
    exp_t e;
    if (q.size() != 0) begin
      e = q.pop_front();
      checks++;
      if ({cpu_rdy, cpu_aec, dma_grant, busy} !== e.ragb ||
          dma_cycles !== e.cyc || s_cycles !== e.cyc4) begin
        failures++;
        $display("FAIL %s: got rdy/aec/grant/busy=%b cyc=%0d cyc4=%0d, expected %b cyc=%0d cyc4=%0d",
                 e.name, {cpu_rdy, cpu_aec, dma_grant, busy},
                 dma_cycles, s_cycles, e.ragb, e.cyc, e.cyc4);
      end
    end
    checks++;
    if ((!cpu_aec && cpu_rdy) || (dma_grant !== ~cpu_aec)) begin
      failures++;
      $display("FAIL invariant at %0t: rdy=%b aec=%b grant=%b, expected aec=0->rdy=0 and grant=~aec",
               $time, cpu_rdy, cpu_aec, dma_grant);
    end
  end

  function automatic exp_t mk(input logic [3:0] ragb, input int c,
                              input string nm);
    exp_t e;
    e.ragb = ragb;
    e.cyc  = 8'(c);
    e.cyc4 = (c > 15) ? 4'd15 : 4'(c);
    e.name = nm;
    return e;
  endfunction

  // One CPU cycle: a strobe clk, then an idle clk where outputs must hold.
  task automatic strobe(input logic req, input logic rw,
                        input logic [3:0] ragb, input int c,
                        input string nm);
    exp_t e;
    dma_req = req;
    cpu_rw  = rw;
    cyc_en  = 1'b1;
    @(posedge clk);
    #1;
    cyc_en = 1'b0;
    e = mk(ragb, c, nm);
    q.push_back(e);
    @(posedge clk);
    #1;
    e.name = {nm, "_hold"};
    q.push_back(e);
  endtask

  // ragb = {rdy, aec, grant, busy}
  localparam logic [3:0] S_IDLE = 4'b1100;
  localparam logic [3:0] S_STL  = 4'b0101;
  localparam logic [3:0] S_DMA  = 4'b0011;
  localparam logic [3:0] S_REL  = 4'b0101;

  initial begin
    reset   = 1'b1;
    cyc_en  = 1'b0;
    dma_req = 1'b0;
    cpu_rw  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    q.push_back(mk(S_IDLE, 0, "reset"));
    @(posedge clk);
    #1;
    reset = 1'b0;

    // basic burst of 5 request strobes
    strobe(1, 0, S_STL,  0, "t1_s1_rdy_low");
    strobe(1, 0, S_STL,  0, "t1_s2");
    strobe(1, 0, S_STL,  0, "t1_s3");
    strobe(1, 0, S_DMA,  0, "t1_s4_grant");
    strobe(1, 0, S_DMA,  1, "t1_s5");
    strobe(0, 0, S_REL,  2, "t1_s6_aec_up");
    strobe(0, 0, S_IDLE, 2, "t1_s7_rdy_up");

    // abort on the strobe where cnt == 0
    strobe(1, 0, S_STL,  0, "t2_s1");
    strobe(1, 0, S_STL,  0, "t2_s2");
    strobe(1, 0, S_STL,  0, "t2_s3");
    strobe(0, 0, S_IDLE, 0, "t2_abort");

    // re-request from RELEASE
    strobe(1, 0, S_STL,  0, "t3_s1");
    strobe(1, 0, S_STL,  0, "t3_s2");
    strobe(1, 0, S_STL,  0, "t3_s3");
    strobe(1, 0, S_DMA,  0, "t3_grant");
    strobe(0, 0, S_REL,  1, "t3_release");
    strobe(1, 0, S_DMA,  1, "t3_regrant");
    strobe(1, 0, S_DMA,  2, "t3_dma");
    strobe(0, 0, S_REL,  3, "t3_release2");
    strobe(0, 0, S_IDLE, 3, "t3_idle");

    // cpu_rw=1 on the first STALL strobe
    strobe(1, 0, S_STL,  0, "t4_s1");
`ifdef CPU_BUS_ARB_FAST_GRANT_EN
    strobe(1, 1, S_DMA,  0, "t4_s2_fast_grant");
    strobe(1, 0, S_DMA,  1, "t4_s3");
    strobe(1, 0, S_DMA,  2, "t4_s4");
    strobe(0, 0, S_REL,  3, "t4_release");
    strobe(0, 0, S_IDLE, 3, "t4_idle");
`else
    strobe(1, 1, S_STL,  0, "t4_s2_no_fast");
    strobe(1, 0, S_STL,  0, "t4_s3");
    strobe(1, 0, S_DMA,  0, "t4_s4_grant");
    strobe(0, 0, S_REL,  1, "t4_release");
    strobe(0, 0, S_IDLE, 1, "t4_idle");
`endif

    // reset mid-burst with cyc_en low
    strobe(1, 0, S_STL,  0, "t5_s1");
    strobe(1, 0, S_STL,  0, "t5_s2");
    strobe(1, 0, S_STL,  0, "t5_s3");
    strobe(1, 0, S_DMA,  0, "t5_grant");
    strobe(1, 0, S_DMA,  1, "t5_dma");
    reset = 1'b1;
    @(posedge clk);
    #1;
    q.push_back(mk(S_IDLE, 0, "t5_reset_mid"));
    reset   = 1'b0;
    dma_req = 1'b0;
    @(posedge clk);
    #1;
    strobe(0, 0, S_IDLE, 0, "t5_after");

    // long burst: 4-bit counter saturates at 15
    strobe(1, 0, S_STL,  0, "t6_s1");
    strobe(1, 0, S_STL,  0, "t6_s2");
    strobe(1, 0, S_STL,  0, "t6_s3");
    strobe(1, 0, S_DMA,  0, "t6_grant");
    for (int k = 1; k <= 20; k++) begin
      strobe(1, 0, S_DMA, k, $sformatf("t6_dma%0d", k));
    end
    strobe(0, 0, S_REL,  21, "t6_release");
    strobe(0, 0, S_IDLE, 21, "t6_idle");

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() != 0) begin
      failures++;
      $display("FAIL queue_drain: %0d entries left, expected 0", q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
